// File: rtl/crop_frame_ctrl_pkg.sv
// Shared constants and types for the crop frame controller.
// Holds the frame geometry, buffer addressing and the controller state type.
package crop_pkg;

  localparam int N_X    = 28;
  localparam int N_Y    = 28;
  localparam int N_PIX  = N_X * N_Y;
  localparam int ADDR_W = 10;

  // Last valid buffer address and the total byte count, pre-sized to ADDR_W.
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIX - 1);
  localparam logic [ADDR_W-1:0] PIX_CNT   = ADDR_W'(N_PIX);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    CAPTURE,
    DRAIN
  } crop_state_e;

endpackage

// File: rtl/crop_frame_ctrl_if.sv
// Sampler-side and transmit-side signals of the crop frame controller.
// The controller connects through the master modport; the sampler/UART
// environment connects through the slave modport.
interface crop_frame_ctrl_if;

  logic       frame_start;
  logic       smp_dval;
  logic [7:0] smp_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    input  frame_start, smp_dval, smp_data, tx_ready,
    output tx_data, tx_valid
  );

  modport slave (
    output frame_start, smp_dval, smp_data, tx_ready,
    input  tx_data, tx_valid
  );

endinterface

// File: rtl/crop_frame_ctrl_buf.sv
// crop_frame_buf: simple dual-port N_PIX x 8 frame buffer.
// One write port and one read port whose data is registered (1-cycle latency).
// The read register only updates on re, so it doubles as a holding stage.
module crop_frame_buf
  import crop_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [N_PIX];
  logic [7:0] rdata_q;

  // Block-RAM style write and registered read, no reset on the array.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/crop_frame_ctrl.sv
// crop_frame_ctrl: captures one 28x28 frame of sampler bytes per iSTART and
// drains it in write order over a valid/ready byte stream.
// Optional stall watchdog enabled by defining CROP_WDOG_EN.
module crop_frame_ctrl
  import crop_pkg::*;
`ifdef CROP_WDOG_EN
#(
  parameter int unsigned WDOG_CYC = 2_000_000
)
`endif
(
  input  logic                iCLK,
  input  logic                iRST,
  input  logic                iSTART,
  input  logic                iABORT,
  crop_frame_ctrl_if.master   bus,
  output logic                oBUSY,
  output logic                oDONE,
  output logic                oERR
);

  crop_state_e       state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              s1_valid_q, s1_valid_d;
  logic              tx_valid_q, tx_valid_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              ram_we, ram_re, advance;
  logic [ADDR_W-1:0] ram_waddr;
  logic [7:0]        ram_rdata;

`ifdef CROP_WDOG_EN
  logic [31:0]       wdog_cnt_q, wdog_cnt_d;
  logic              wdog_active, wdog_clear;
`endif

  crop_frame_buf u_buf (
    .clk   (iCLK),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (bus.smp_data),
    .re    (ram_re),
    .raddr (rd_addr_q),
    .rdata (ram_rdata)
  );

  // Next-state logic: capture sequencing plus a two-stage drain pipeline
  // (RAM read register, then output register) so the stream runs bubble-free.
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    rd_addr_d  = rd_addr_q;
    s1_valid_d = s1_valid_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    done_d     = 1'b0;
    err_d      = err_q;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    ram_waddr  = wr_addr_q;
    advance    = !tx_valid_q || bus.tx_ready;
`ifdef CROP_WDOG_EN
    wdog_cnt_d  = 32'd0;
    wdog_active = 1'b0;
    wdog_clear  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (iSTART) begin
          state_d = ARM;
          err_d   = 1'b0;
        end
      end
      ARM: begin
        if (bus.frame_start) begin
          state_d   = CAPTURE;
          wr_addr_d = '0;
        end
      end
      CAPTURE: begin
        if (bus.frame_start) begin
          err_d     = 1'b1;
          ram_waddr = '0;
          ram_we    = bus.smp_dval;
          wr_addr_d = bus.smp_dval ? ADDR_W'(1) : '0;
        end else if (bus.smp_dval) begin
          ram_we = 1'b1;
          if (wr_addr_q == LAST_ADDR) begin
            state_d    = DRAIN;
            rd_addr_d  = '0;
            s1_valid_d = 1'b0;
            tx_valid_d = 1'b0;
          end else begin
            wr_addr_d = wr_addr_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        ram_re = (advance || !s1_valid_q) && (rd_addr_q < PIX_CNT);
        if (ram_re) rd_addr_d = rd_addr_q + ADDR_W'(1);
        if (advance) begin
          tx_valid_d = s1_valid_q;
          if (s1_valid_q) tx_data_d = ram_rdata;
        end
        s1_valid_d = ram_re ? 1'b1 : (advance ? 1'b0 : s1_valid_q);
        if (tx_valid_q && bus.tx_ready && !s1_valid_q && rd_addr_q == PIX_CNT) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef CROP_WDOG_EN
    wdog_active = (state_q == ARM) || (state_q == CAPTURE);
    wdog_clear  = bus.frame_start || bus.smp_dval;
    if (wdog_active && !wdog_clear) begin
      if (wdog_cnt_q == WDOG_CYC - 1) begin
        state_d = IDLE;
        err_d   = 1'b1;
      end else begin
        wdog_cnt_d = wdog_cnt_q + 32'd1;
      end
    end
`endif

    if (iABORT) begin
      state_d    = IDLE;
      s1_valid_d = 1'b0;
      tx_valid_d = 1'b0;
      done_d     = 1'b0;
      err_d      = err_q;
      ram_we     = 1'b0;
`ifdef CROP_WDOG_EN
      wdog_cnt_d = 32'd0;
`endif
    end
  end

  // Controller registers with asynchronous active-low reset.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      s1_valid_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
      s1_valid_q <= s1_valid_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

`ifdef CROP_WDOG_EN
  // Stall counter register; restarts whenever the state changes.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) wdog_cnt_q <= 32'd0;
    else       wdog_cnt_q <= (state_d != state_q) ? 32'd0 : wdog_cnt_d;
  end
`endif

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;
  assign oBUSY        = (state_q != IDLE);
  assign oDONE        = done_q;
  assign oERR         = err_q;

endmodule
